// File: rtl/dmem_pkg.sv
// Shared encodings and FSM state type for the data memory controller.
// DMEM_SUBWORD_EN enables byte/half accesses; otherwise only words are legal.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

`ifdef DMEM_SUBWORD_EN
  typedef enum logic [1:0] {
    IDLE,
    RD,
    MERGE,
    RESP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RD,
    RESP
  } state_t;
`endif

  // Misaligned, illegal-size or undecoded requests never touch the RAM.
  function automatic logic reqFault(
    input logic       inv,
    input logic [1:0] sz,
    input logic [1:0] off
  );
`ifdef DMEM_SUBWORD_EN
    reqFault = inv
      || (sz == 2'd3)
      || (sz == SZ_HALF && off[0])
      || (sz == SZ_WORD && off != 2'b00);
`else
    reqFault = inv
      || (sz != SZ_WORD)
      || (off != 2'b00);
`endif
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word-wide RAM, synchronous read.
// Read-during-write returns the old word.
module dmem_ram #(
  parameter int    ADDR_W   = 11,
  parameter string MEM_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller with lane extraction and read-modify-write stores.
// Optional DMEM_SUBWORD_EN adds byte/half support and the MERGE state.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int    ADDR_W   = 11,
  parameter string MEM_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] physicalAddr,
  input  logic [1:0]        byteOff,
  input  logic              invAddr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault
);

  state_t state;
  state_t nextState;

  logic              accept;
  logic              faultNow;
  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic              faultQ;
  logic [31:0]       rdataQ;

  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0]       ramWdata;
  logic [31:0]       ramRdata;
  logic [31:0]       loadData;

  assign ready    = (state == IDLE);
  assign done     = (state == RESP);
  assign fault    = done && faultQ;
  assign rdata    = rdataQ;
  assign accept   = req && ready;
  assign faultNow = reqFault(invAddr, size, byteOff);

`ifdef DMEM_SUBWORD_EN
  logic [1:0]  sizeQ;
  logic        signExtQ;
  logic [1:0]  byteOffQ;
  logic [15:0] wdataQ;
  logic [31:0] shifted;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] mergeData;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    shifted  = ramRdata >> {byteOffQ, 3'b000};
    laneByte = shifted[7:0];
    laneHalf = byteOffQ[1] ? ramRdata[31:16] : ramRdata[15:0];
    unique case (sizeQ)
      SZ_BYTE: loadData = {{24{signExtQ & laneByte[7]}}, laneByte};
      SZ_HALF: loadData = {{16{signExtQ & laneHalf[15]}}, laneHalf};
      default: loadData = ramRdata;
    endcase
  end

  // Replace only the addressed lane of the word read back in RD.
  always_comb begin
    mergeData = ramRdata;
    if (sizeQ == SZ_BYTE) begin
      unique case (byteOffQ)
        2'd0: mergeData[7:0]   = wdataQ[7:0];
        2'd1: mergeData[15:8]  = wdataQ[7:0];
        2'd2: mergeData[23:16] = wdataQ[7:0];
        2'd3: mergeData[31:24] = wdataQ[7:0];
        default: mergeData = ramRdata;
      endcase
    end else if (byteOffQ[1]) begin
      mergeData[31:16] = wdataQ;
    end else begin
      mergeData[15:0] = wdataQ;
    end
  end

  // Sub-word request fields captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sizeQ    <= SZ_WORD;
      signExtQ <= 1'b0;
      byteOffQ <= 2'b00;
      wdataQ   <= 16'h0;
    end else if (accept) begin
      sizeQ    <= size;
      signExtQ <= signExt;
      byteOffQ <= byteOff;
      wdataQ   <= wdata[15:0];
    end
  end
`else
  logic unusedSignExt;

  assign unusedSignExt = signExt;
  assign loadData      = ramRdata;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state: faults and word stores finish in one step.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (faultNow || (we && size == SZ_WORD))
            nextState = RESP;
          else
            nextState = RD;
        end
      end
`ifdef DMEM_SUBWORD_EN
      RD:    nextState = weQ ? MERGE : RESP;
      MERGE: nextState = RESP;
`else
      RD:    nextState = RESP;
`endif
      RESP:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // RAM port steering; writes are blocked while reset is asserted.
  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = addrQ;
    ramWdata = wdata;
    if (state == IDLE) begin
      ramAddr = physicalAddr;
      ramWe   = req && we && !faultNow && (size == SZ_WORD);
    end
`ifdef DMEM_SUBWORD_EN
    if (state == MERGE) begin
      ramWe    = 1'b1;
      ramWdata = mergeData;
    end
`endif
    ramWe = ramWe && rst_n;
  end

  // Common request fields captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ  <= '0;
      weQ    <= 1'b0;
      faultQ <= 1'b0;
    end else if (accept) begin
      addrQ  <= physicalAddr;
      weQ    <= we;
      faultQ <= faultNow;
    end
  end

  // Load result registered on the RD to RESP edge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rdataQ <= 32'h0;
    else if (state == RD && !weQ) rdataQ <= loadData;
  end

  dmem_ram #(
    .ADDR_W  (ADDR_W),
    .MEM_FILE(MEM_FILE)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

endmodule
